// File: rtl/pin_locker.sv
// Serial multi-digit PIN lock: checks against a programmable PIN, counts failures,
// locks out after MAX_TRIES and releases on a timer or on the master PIN.
//
// state  | meaning
// IDLE   | collecting a user PIN entry
// CHECK  | one-cycle compare of the assembled code against pin_reg
// OPEN   | unlocked, open timer counting down to auto-relock
// PROG   | unlocked, collecting a new user PIN
// LOCKED | locked out; only the master PIN or the lock timer releases
module pin_locker #(
  parameter int DIGIT_W     = 4,
  parameter int NUM_DIGITS  = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 32,
  parameter int OPEN_CYCLES = 16,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_PIN = 16'h8003,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] MASTER_PIN  = 16'h1000
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                digit_valid,
  input  logic [DIGIT_W-1:0]                  digit_in,
  input  logic                                clear,
  input  logic                                lock_req,
  input  logic                                prog_req,
  output logic [1:0]                          y_out,
  output logic                                unlocked,
  output logic                                locked,
  output logic [$clog2(MAX_TRIES+1)-1:0]      fail_cnt,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     digits_entered,
  output logic                                master_ok
);

  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int TMAX   = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TMR_W  = $clog2(TMAX + 1);
  // Timer terminates at zero, so load N-1 to stay in the state for N clocks.
  localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD = (LOCK_CYCLES > 0) ? TMR_W'(LOCK_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_OPEN   = 3'd2,
    S_PROG   = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [CODE_W-1:0]   entry, entry_nx;
  logic [CODE_W-1:0]   code, code_nx;
  logic [CODE_W-1:0]   pin_reg, pin_nx;
  logic [CODE_W-1:0]   assembled;
  logic [CNT_W-1:0]    cnt_nx;
  logic [FAIL_W-1:0]   fail_nx;
  logic [TMR_W-1:0]    timer, timer_nx;
  logic                capture, last_digit, master_nx;
  logic [1:0]          y_nx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      entry          <= '0;
      code           <= '0;
      pin_reg        <= DEFAULT_PIN;
      digits_entered <= '0;
      fail_cnt       <= '0;
      timer          <= '0;
      master_ok      <= 1'b0;
      y_out          <= 2'b00;
      unlocked       <= 1'b0;
      locked         <= 1'b0;
    end else begin
      state          <= state_nx;
      entry          <= entry_nx;
      code           <= code_nx;
      pin_reg        <= pin_nx;
      digits_entered <= cnt_nx;
      fail_cnt       <= fail_nx;
      timer          <= timer_nx;
      master_ok      <= master_nx;
      y_out          <= y_nx;
      unlocked       <= (state_nx == S_OPEN) || (state_nx == S_PROG);
      locked         <= (state_nx == S_LOCKED);
    end
  end

  always_comb begin
    state_nx   = state;
    entry_nx   = entry;
    code_nx    = code;
    pin_nx     = pin_reg;
    cnt_nx     = digits_entered;
    fail_nx    = fail_cnt;
    timer_nx   = timer;
    master_nx  = 1'b0;
    assembled  = (entry << DIGIT_W) | CODE_W'(digit_in);
    last_digit = (digits_entered == CNT_W'(NUM_DIGITS - 1));
    capture    = digit_valid && !clear &&
                 ((state == S_IDLE) || (state == S_PROG) || (state == S_LOCKED));

    if (clear) begin
      entry_nx = '0;
      cnt_nx   = '0;
    end else if (capture) begin
      if (last_digit) begin
        entry_nx = '0;
        cnt_nx   = '0;
        code_nx  = assembled;
      end else begin
        entry_nx = assembled;
        cnt_nx   = digits_entered + CNT_W'(1);
      end
    end

    case (state)
      S_IDLE: begin
        if (capture && last_digit) state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (code == pin_reg) begin
          state_nx = S_OPEN;
          fail_nx  = '0;
          timer_nx = OPEN_LOAD;
        end else if (fail_cnt >= FAIL_W'(MAX_TRIES - 1)) begin
          state_nx = S_LOCKED;
          fail_nx  = FAIL_W'(MAX_TRIES);
          timer_nx = LOCK_LOAD;
        end else begin
          state_nx = S_IDLE;
          fail_nx  = fail_cnt + FAIL_W'(1);
        end
      end
      S_OPEN: begin
        if (lock_req) begin
          state_nx = S_IDLE;
        end else if (prog_req) begin
          state_nx = S_PROG;
          entry_nx = '0;
          cnt_nx   = '0;
        end else if (timer == '0) begin
          state_nx = S_IDLE;
        end else begin
          timer_nx = timer - TMR_W'(1);
        end
      end
      S_PROG: begin
        if (clear) begin
          state_nx = S_IDLE;
        end else if (capture && last_digit) begin
          pin_nx   = assembled;
          state_nx = S_IDLE;
        end
      end
      S_LOCKED: begin
        // Master match beats a same-edge timer expiry so the release is reported.
        if (capture && last_digit && (assembled == MASTER_PIN)) begin
          state_nx  = S_IDLE;
          fail_nx   = '0;
          master_nx = 1'b1;
        end else if (LOCK_CYCLES > 0) begin
          if (timer == '0) begin
            state_nx = S_IDLE;
            fail_nx  = '0;
            entry_nx = '0;
            cnt_nx   = '0;
          end else begin
            timer_nx = timer - TMR_W'(1);
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if ((state_nx == S_OPEN) || (state_nx == S_PROG)) y_nx = 2'b11;
    else if (state_nx == S_LOCKED)                     y_nx = 2'b10;
    else if (fail_nx != '0)                            y_nx = 2'b01;
    else                                               y_nx = 2'b00;
  end

endmodule

// File: tb/tb_pin_locker.sv
// Directed bench for pin_locker: entry, lockout, master/timed release,
// reprogramming, simultaneous events and async reset.
module tb_pin_locker;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit_in = '0;
  logic       clear = 1'b0;
  logic       lock_req = 1'b0;
  logic       prog_req = 1'b0;
  logic [1:0] y_out;
  logic       unlocked;
  logic       locked;
  logic [1:0] fail_cnt;
  logic [2:0] digits_entered;
  logic       master_ok;

  int errors = 0;
  int checks = 0;

  pin_locker dut (
    .clock          (clock),
    .reset          (reset),
    .digit_valid    (digit_valid),
    .digit_in       (digit_in),
    .clear          (clear),
    .lock_req       (lock_req),
    .prog_req       (prog_req),
    .y_out          (y_out),
    .unlocked       (unlocked),
    .locked         (locked),
    .fail_cnt       (fail_cnt),
    .digits_entered (digits_entered),
    .master_ok      (master_ok)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enter_digit(input logic [3:0] d);
    digit_valid = 1'b1;
    digit_in    = d;
    tick(1);
    digit_valid = 1'b0;
  endtask

  task automatic enter_pin(input logic [15:0] p);
    for (int i = 0; i < 4; i++) enter_digit(p[15-4*i -: 4]);
  endtask

  initial begin
    #2;
    check("rst_y", y_out, 2'b00);
    check("rst_unlocked", unlocked, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_master_ok", master_ok, 1'b0);
    check("rst_fail", fail_cnt, 2'd0);
    #10 reset = 1'b1;
    tick(1);

    // Correct PIN, then auto-relock after 16 clocks
    enter_pin(16'h8003);
    check("check_state_y", y_out, 2'b00);
    check("check_digits", digits_entered, 3'd0);
    tick(1);
    check("open_y", y_out, 2'b11);
    check("open_unlocked", unlocked, 1'b1);
    tick(15);
    check("open_last_y", y_out, 2'b11);
    tick(1);
    check("relock_y", y_out, 2'b00);
    check("relock_unlocked", unlocked, 1'b0);

    // Lockout after three wrong attempts
    enter_pin(16'h1234); tick(1);
    check("fail1_cnt", fail_cnt, 2'd1);
    check("fail1_y", y_out, 2'b01);
    enter_digit(4'h1);
    check("partial_digits", digits_entered, 3'd1);
    enter_pin(16'h2340); tick(1);
    check("fail2_cnt", fail_cnt, 2'd2);
    check("fail2_y", y_out, 2'b01);
    enter_pin(16'h1234); tick(1);
    check("lock_locked", locked, 1'b1);
    check("lock_y", y_out, 2'b10);
    check("lock_fail", fail_cnt, 2'd3);
    enter_pin(16'h8003);
    check("lock_user_pin_locked", locked, 1'b1);
    check("lock_user_pin_fail", fail_cnt, 2'd3);
    check("lock_user_pin_digits", digits_entered, 3'd0);

    // Master release
    enter_pin(16'h1000);
    check("master_ok_pulse", master_ok, 1'b1);
    check("master_y", y_out, 2'b00);
    check("master_fail", fail_cnt, 2'd0);
    check("master_locked", locked, 1'b0);
    tick(1);
    check("master_ok_drop", master_ok, 1'b0);

    // Timed release after 32 clocks
    for (int k = 0; k < 3; k++) begin
      enter_pin(16'h5555); tick(1);
    end
    check("relock_locked", locked, 1'b1);
    tick(31);
    check("timed_still_locked", locked, 1'b1);
    tick(1);
    check("timed_released", locked, 1'b0);
    check("timed_y", y_out, 2'b00);
    check("timed_fail", fail_cnt, 2'd0);
    check("timed_no_master", master_ok, 1'b0);

    // Reprogramming
    enter_pin(16'h8003); tick(1);
    prog_req = 1'b1; tick(1); prog_req = 1'b0;
    check("prog_y", y_out, 2'b11);
    check("prog_unlocked", unlocked, 1'b1);
    enter_pin(16'h4242);
    check("prog_done_y", y_out, 2'b00);
    check("prog_done_unlocked", unlocked, 1'b0);
    enter_pin(16'h8003); tick(1);
    check("old_pin_fail", fail_cnt, 2'd1);
    check("old_pin_y", y_out, 2'b01);
    enter_pin(16'h4242); tick(1);
    check("new_pin_open", y_out, 2'b11);
    check("new_pin_fail", fail_cnt, 2'd0);

    // PROG aborted by clear keeps pin 4242
    prog_req = 1'b1; tick(1); prog_req = 1'b0;
    enter_digit(4'h7); enter_digit(4'h7);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("prog_abort_y", y_out, 2'b00);
    enter_pin(16'h4242); tick(1);
    check("prog_abort_pin_kept", y_out, 2'b11);

    // Reset reverts the PIN
    reset = 1'b0; #1;
    check("rst_open_y", y_out, 2'b00);
    #2 reset = 1'b1;
    tick(1);
    enter_pin(16'h8003); tick(1);
    check("default_pin_back", y_out, 2'b11);

    // lock_req beats prog_req
    lock_req = 1'b1; prog_req = 1'b1; tick(1);
    lock_req = 1'b0; prog_req = 1'b0;
    check("lock_wins_y", y_out, 2'b00);
    check("lock_wins_unlocked", unlocked, 1'b0);

    // clear beats digit_valid
    enter_digit(4'h1); enter_digit(4'h2);
    check("two_digits", digits_entered, 3'd2);
    digit_valid = 1'b1; digit_in = 4'h5; clear = 1'b1;
    tick(1);
    digit_valid = 1'b0; clear = 1'b0;
    check("clear_wins_digits", digits_entered, 3'd0);
    check("clear_keeps_fail", fail_cnt, 2'd0);

    // digit during CHECK is ignored
    enter_pin(16'h9999);
    enter_digit(4'h7);
    check("check_ignore_digits", digits_entered, 3'd0);
    check("check_ignore_fail", fail_cnt, 2'd1);

    // Async reset mid-lockout, timer at 10
    enter_pin(16'h1234); tick(1);
    enter_pin(16'h1234); tick(1);
    check("lock2_locked", locked, 1'b1);
    tick(21);
    check("lock2_still_locked", locked, 1'b1);
    reset = 1'b0; #1;
    check("async_y", y_out, 2'b00);
    check("async_locked", locked, 1'b0);
    check("async_fail", fail_cnt, 2'd0);
    check("async_unlocked", unlocked, 1'b0);
    #2 reset = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
